texture_buffer_loader: RTL and testbench



---
 rtl/texture_buffer_pkg.sv | 21 ++
 rtl/texture_buffer_loader_if.sv | 25 ++
 rtl/texture_dual_bank_ram.sv | 34 +++
 rtl/texture_buffer_loader.sv | 95 +++++++++
 tb/tb_texture_buffer_loader.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/texture_buffer_pkg.sv
// Shared constants for the ping-pong texture loader: FSM encoding and bank sizing.
// Latency: n/a (package only).
// Backpressure: n/a.
package texture_buffer_pkg;

    localparam int DEFAULT_TEXTURE_STREAM_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH           = 15;

    // Texels per bank at the default geometry.
    localparam int BANK_WORDS = 1 << DEFAULT_ADDR_WIDTH;

    // Loader FSM: accept beats into the back bank, or hold a finished texture until swap.
    localparam logic [0:0] ST_LOAD         = 1'b0;
    localparam logic [0:0] ST_PENDING_SWAP = 1'b1;

    // Per-bank capacity for an arbitrary address width.
    function automatic int bank_words(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/texture_buffer_loader_if.sv
// AXI-Stream texel channel from the command parser into the texture loader.
// Latency: n/a (wires only).
// Backpressure: tready from the slave stalls the master; beats move on tvalid && tready.
interface texture_buffer_loader_if #(
    parameter int TEXTURE_STREAM_WIDTH = 16
);
    logic                            s_texture_axis_tvalid;
    logic                            s_texture_axis_tready;
    logic                            s_texture_axis_tlast;
    logic [TEXTURE_STREAM_WIDTH-1:0] s_texture_axis_tdata;

    modport master (
        output s_texture_axis_tvalid,
        output s_texture_axis_tlast,
        output s_texture_axis_tdata,
        input  s_texture_axis_tready
    );

    modport slave (
        input  s_texture_axis_tvalid,
        input  s_texture_axis_tlast,
        input  s_texture_axis_tdata,
        output s_texture_axis_tready
    );
endinterface

// File: rtl/texture_dual_bank_ram.sv
// Simple dual-port texel RAM holding both banks; the bank is the address MSB.
// Latency: 1 cycle registered read, write lands at the clock edge.
// Backpressure: none, both ports accept every cycle.
module texture_dual_bank_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    // No reset on the array so it maps onto block RAM.
    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; only the output register is reset so texelData starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/texture_buffer_loader.sv
// Ping-pong texture store: uploads fill the back bank, rasterizer reads the front bank.
// Latency: texel read 1 cycle; swap at the earliest 1 cycle after the tlast beat.
// Backpressure: tready low from tlast until the swap, which waits for rasterizerRunning = 0.
module texture_buffer_loader
    import texture_buffer_pkg::*;
#(
    parameter int TEXTURE_STREAM_WIDTH = DEFAULT_TEXTURE_STREAM_WIDTH,
    parameter int ADDR_WIDTH           = DEFAULT_ADDR_WIDTH
) (
    input  logic                            aclk,
    input  logic                            resetn,
    texture_buffer_loader_if.slave          axis,
    input  logic                            rasterizerRunning,
    input  logic [ADDR_WIDTH-1:0]           texelAddr,
    output logic [TEXTURE_STREAM_WIDTH-1:0] texelData,
    output logic                            textureValid,
    output logic [ADDR_WIDTH:0]             textureWords,
    output logic                            textureOverflow,
    output logic                            bankSwapped
);
    logic [0:0]        state;
    logic              front;
    logic              out_of_reset;
    logic [ADDR_WIDTH:0] wr_addr;
    logic [ADDR_WIDTH:0] pend_words;
    logic              pend_overflow;
    logic              beat;
    logic              bank_full;

    // out_of_reset keeps tready low until the first edge after reset release.
    assign axis.s_texture_axis_tready = out_of_reset && (state == ST_LOAD);
    assign beat      = axis.s_texture_axis_tvalid && axis.s_texture_axis_tready;
    // wr_addr reaching 2^ADDR_WIDTH means the bank is full; further beats are dropped.
    assign bank_full = wr_addr[ADDR_WIDTH];

    // Upload FSM, write pointer and the front-bank descriptor updated on swap.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state           <= ST_LOAD;
            front           <= 1'b0;
            out_of_reset    <= 1'b0;
            wr_addr         <= '0;
            pend_words      <= '0;
            pend_overflow   <= 1'b0;
            textureValid    <= 1'b0;
            textureWords    <= '0;
            textureOverflow <= 1'b0;
            bankSwapped     <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
            bankSwapped  <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (beat) begin
                        if (bank_full) begin
                            pend_overflow <= 1'b1;
                        end else begin
                            wr_addr <= wr_addr + 1'b1;
                        end
                        if (axis.s_texture_axis_tlast) begin
                            // Count includes this beat only if it was actually stored.
                            pend_words <= bank_full ? wr_addr : wr_addr + 1'b1;
                            state      <= ST_PENDING_SWAP;
                        end
                    end
                end
                default: begin
                    if (!rasterizerRunning) begin
                        front           <= ~front;
                        textureWords    <= pend_words;
                        textureOverflow <= pend_overflow;
                        textureValid    <= 1'b1;
                        bankSwapped     <= 1'b1;
                        wr_addr         <= '0;
                        pend_overflow   <= 1'b0;
                        state           <= ST_LOAD;
                    end
                end
            endcase
        end
    end

    texture_dual_bank_ram #(
        .DATA_WIDTH (TEXTURE_STREAM_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH + 1)
    ) u_ram (
        .clk     (aclk),
        .rst_n   (resetn),
        .wr_en   (beat && !bank_full),
        .wr_addr ({~front, wr_addr[ADDR_WIDTH-1:0]}),
        .wr_data (axis.s_texture_axis_tdata),
        .rd_addr ({front, texelAddr}),
        .rd_data (texelData)
    );
endmodule

// File: tb/tb_texture_buffer_loader.sv
// Self-checking bench for texture_buffer_loader at ADDR_WIDTH = 3 (8-texel banks).
// Latency: n/a.
// Backpressure: n/a.
module tb_texture_buffer_loader;
    localparam int W   = 16;
    localparam int AW  = 3;
    localparam int CAP = 1 << AW;

    logic          aclk = 1'b0;
    logic          resetn = 1'b0;
    logic          rasterizerRunning = 1'b0;
    logic [AW-1:0] texelAddr = '0;
    logic [W-1:0]  texelData;
    logic          textureValid;
    logic [AW:0]   textureWords;
    logic          textureOverflow;
    logic          bankSwapped;

    texture_buffer_loader_if #(.TEXTURE_STREAM_WIDTH(W)) axis_if ();

    texture_buffer_loader #(
        .TEXTURE_STREAM_WIDTH (W),
        .ADDR_WIDTH           (AW)
    ) dut (
        .aclk              (aclk),
        .resetn            (resetn),
        .axis              (axis_if),
        .rasterizerRunning (rasterizerRunning),
        .texelAddr         (texelAddr),
        .texelData         (texelData),
        .textureValid      (textureValid),
        .textureWords      (textureWords),
        .textureOverflow   (textureOverflow),
        .bankSwapped       (bankSwapped)
    );

    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;

    // Reference model of what the rasterizer should see in the front bank.
    logic [W-1:0] exp_mem [CAP];
    int           exp_words = 0;
    bit           exp_ovf   = 1'b0;
    bit           exp_valid = 1'b0;

    // A finished upload of n beats: the first min(n, CAP) texels are visible, rest dropped.
    function automatic void model_commit(input logic [W-1:0] q[$]);
        exp_words = (q.size() > CAP) ? CAP : q.size();
        exp_ovf   = (q.size() > CAP);
        for (int i = 0; i < exp_words; i++) exp_mem[i] = q[i];
        exp_valid = 1'b1;
    endfunction

    // Drive one texture, optionally idling a cycle before each beat; returns after the tlast handshake.
    task automatic send_texture(input logic [W-1:0] q[$], input bit gaps, output bit ok);
        int waited;
        ok = 1'b1;
        for (int i = 0; i < q.size(); i++) begin
            if (gaps && i > 0) begin
                axis_if.s_texture_axis_tvalid = 1'b0;
                axis_if.s_texture_axis_tlast  = 1'($urandom);
                axis_if.s_texture_axis_tdata  = W'($urandom);
                @(posedge aclk); #1;
            end
            axis_if.s_texture_axis_tvalid = 1'b1;
            axis_if.s_texture_axis_tdata  = q[i];
            axis_if.s_texture_axis_tlast  = (i == q.size() - 1);
            waited = 0;
            while (axis_if.s_texture_axis_tready !== 1'b1 && waited < 64) begin
                @(posedge aclk); #1;
                waited++;
            end
            if (waited >= 64) ok = 1'b0;
            @(posedge aclk); #1;
        end
        axis_if.s_texture_axis_tvalid = 1'b0;
        axis_if.s_texture_axis_tlast  = 1'b0;
    endtask

    // Full upload scenario: tready drop, optional hold, swap pulse, descriptor and readback.
    task automatic run_upload(input string tag, input logic [W-1:0] q[$], input bit gaps, input int hold);
        bit           ok;
        bit           old_valid;
        logic [W-1:0] old0;
        rasterizerRunning = (hold > 0);
        texelAddr = '0;
        send_texture(q, gaps, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL %s handshake_timeout got=timeout want=accept", tag); end
        tests++;
        if (axis_if.s_texture_axis_tready !== 1'b0) begin
            fails++; $display("FAIL %s tready_after_tlast got=%b want=0", tag, axis_if.s_texture_axis_tready);
        end
        old_valid = exp_valid;
        old0      = exp_mem[0];
        for (int c = 0; c < hold; c++) begin
            @(posedge aclk); #1;
            tests++;
            if (axis_if.s_texture_axis_tready !== 1'b0 || bankSwapped !== 1'b0) begin
                fails++; $display("FAIL %s hold_no_swap got=tready%b/swap%b want=0/0", tag, axis_if.s_texture_axis_tready, bankSwapped);
            end
            if (old_valid) begin
                tests++;
                if (texelData !== old0) begin fails++; $display("FAIL %s hold_front_read got=%h want=%h", tag, texelData, old0); end
            end
        end
        rasterizerRunning = 1'b0;
        @(posedge aclk); #1;
        tests++;
        if (bankSwapped !== 1'b1 || axis_if.s_texture_axis_tready !== 1'b1) begin
            fails++; $display("FAIL %s swap_edge got=swap%b/tready%b want=1/1", tag, bankSwapped, axis_if.s_texture_axis_tready);
        end
        if (old_valid) begin
            tests++;
            if (texelData !== old0) begin fails++; $display("FAIL %s swap_edge_read_old got=%h want=%h", tag, texelData, old0); end
        end
        model_commit(q);
        tests++;
        if (textureValid !== 1'b1 || textureWords !== (AW+1)'(exp_words) || textureOverflow !== exp_ovf) begin
            fails++; $display("FAIL %s descriptor got=v%b/w%0d/o%b want=1/%0d/%b", tag, textureValid, textureWords, textureOverflow, exp_words, exp_ovf);
        end
        @(posedge aclk); #1;
        tests++;
        if (bankSwapped !== 1'b0) begin fails++; $display("FAIL %s swap_pulse_width got=%b want=0", tag, bankSwapped); end
        for (int a = 0; a < exp_words; a++) begin
            texelAddr = AW'(a);
            @(posedge aclk); #1;
            tests++;
            if (texelData !== exp_mem[a]) begin fails++; $display("FAIL %s read[%0d] got=%h want=%h", tag, a, texelData, exp_mem[a]); end
        end
    endtask

    task automatic test_reset();
        axis_if.s_texture_axis_tvalid = 1'b0;
        axis_if.s_texture_axis_tlast  = 1'b0;
        axis_if.s_texture_axis_tdata  = '0;
        resetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        tests++;
        if (axis_if.s_texture_axis_tready !== 1'b0 || textureValid !== 1'b0 || textureWords !== '0 ||
            textureOverflow !== 1'b0 || bankSwapped !== 1'b0 || texelData !== '0) begin
            fails++; $display("FAIL reset_values got=r%b/v%b/w%0d/o%b/s%b/d%h want=0/0/0/0/0/0",
                axis_if.s_texture_axis_tready, textureValid, textureWords, textureOverflow, bankSwapped, texelData);
        end
        resetn = 1'b1;
        #1;
        tests++;
        if (axis_if.s_texture_axis_tready !== 1'b0) begin fails++; $display("FAIL reset_release_tready got=%b want=0", axis_if.s_texture_axis_tready); end
        @(posedge aclk); #1;
        tests++;
        if (axis_if.s_texture_axis_tready !== 1'b1) begin fails++; $display("FAIL first_edge_tready got=%b want=1", axis_if.s_texture_axis_tready); end
        exp_valid = 1'b0;
    endtask

    task automatic test_basic();
        run_upload("basic", '{16'h1111, 16'h2222, 16'h3333, 16'h4444}, 1'b0, 0);
    endtask

    task automatic test_hold();
        run_upload("hold", '{16'hAAAA, 16'hBBBB}, 1'b0, 3);
    endtask

    task automatic test_gaps();
        logic [W-1:0] q[$];
        for (int i = 0; i < CAP; i++) q.push_back(W'($urandom));
        run_upload("gaps_full_bank", q, 1'b1, 0);
    endtask

    task automatic test_overflow();
        logic [W-1:0] q[$];
        for (int i = 0; i < CAP + 2; i++) q.push_back(W'($urandom));
        run_upload("overflow", q, 1'b0, 0);
        run_upload("overflow_clear", '{16'h5A5A, 16'hA5A5}, 1'b0, 0);
    endtask

    task automatic test_single();
        run_upload("single_beat", '{16'h0F0F}, 1'b0, 0);
    endtask

    task automatic test_random();
        logic [W-1:0] q[$];
        for (int t = 0; t < 6; t++) begin
            q.delete();
            for (int i = 0, n = $urandom_range(1, CAP + 3); i < n; i++) q.push_back(W'($urandom));
            run_upload("random", q, 1'($urandom), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_midreset();
        rasterizerRunning = 1'b1;
        for (int i = 0; i < 3; i++) begin
            axis_if.s_texture_axis_tvalid = 1'b1;
            axis_if.s_texture_axis_tdata  = W'($urandom);
            axis_if.s_texture_axis_tlast  = 1'b0;
            @(posedge aclk); #1;
        end
        resetn = 1'b0;
        axis_if.s_texture_axis_tvalid = 1'b0;
        #1;
        tests++;
        if (axis_if.s_texture_axis_tready !== 1'b0 || textureValid !== 1'b0 || textureWords !== '0) begin
            fails++; $display("FAIL midreset_async got=r%b/v%b/w%0d want=0/0/0", axis_if.s_texture_axis_tready, textureValid, textureWords);
        end
        exp_valid = 1'b0;
        @(posedge aclk); #1;
        resetn = 1'b1;
        @(posedge aclk); #1;
        tests++;
        if (axis_if.s_texture_axis_tready !== 1'b1) begin fails++; $display("FAIL midreset_release_tready got=%b want=1", axis_if.s_texture_axis_tready); end
        run_upload("after_reset", '{16'hC001, 16'hC002, 16'hC003}, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_gaps();
        test_overflow();
        test_single();
        test_random();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=no_finish want=finish");
        $fatal(1);
    end
endmodule
